matmul_operand_sequencer: RTL and testbench
===========================================

Name: matmul_operand_sequencer

Overview:
- Initiator side of the 2x2 signed matrix-multiply stream interface.
- Holds two 2x2 signed 8-bit operand matrices A and B, loaded through a simple write port.
- On go, drives start/A/B toward the multiply-accumulate consumer with the consumer's fixed 5-cycle-per-dot-product timing, then captures the four strobed 17-bit results into a C register file.
- Sits between the control/CPU-side register interface and the matrix multiplier datapath.

Parameters:
DW, 8, operand width (signed)
OW, 17, result width (signed), equals 2*DW+1
TIMEOUT, 32, drain-phase watchdog limit in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
NRST  in  1  asynchronous active-low reset
ld_en  in  1  operand write strobe
ld_sel  in  1  0 = write matrix A, 1 = write matrix B
ld_addr  in  2  element index, row*2+col
ld_data  in  DW  signed element value
go  in  1  start one 2x2 multiply
busy  out  1  high from go acceptance until done
done  out  1  one-cycle pulse when all four results are captured
mm_start  out  1  consumer start/hold
mm_a  out  DW  signed A operand to consumer
mm_b  out  DW  signed B operand to consumer
mm_out  in  OW  signed consumer result
mm_strobe  in  1  consumer result-valid
c_rd_addr  in  2  result index, row*2+col
c_rd_data  out  OW  combinational read of C[c_rd_addr]

Behaviour:
- Reset is asynchronous and active-low on NRST; one clock, CLK.
- Reset values: busy=0, done=0, mm_start=0, mm_a=0, mm_b=0. A, B and C register files are 0. Feed counter and result count are 0. State is IDLE.
- States and transitions:
  - IDLE: go=1 clears the result count and enters FEED with t=0.
  - FEED: runs t=0..19, one step per cycle; leaves to DRAIN at t=20.
  - DRAIN: waits for result count=4, then goes to DONE.
  - DONE: done=1 for one cycle, then returns to IDLE.
- All outputs are registered. mm_start=1 exactly while in FEED (20 cycles), and 0 otherwise.
- Operand schedule:
  - Dot product j=0..3 maps to C element j (row r=j>>1, col c=j&1).
  - At t=1+5j+3k (k=0,1), drive mm_a=A[r][k] and mm_b=B[k][c].
  - Drive mm_a=mm_b=0 in every other cycle.
- Consumer contract: it samples its operands on the edges ending t=1+5j and t=4+5j. Its result strobe rises at t=6, 11, 16 and 21. The strobe may stay high 1-2 cycles, and mm_out is valid only in the first strobe cycle.
- Capture:
  - On the rising edge of mm_strobe (current=1, previous=0) while busy and count<4, write C[count]<=mm_out and increment count.
  - Ignore extra strobes and strobes seen while IDLE.
  - Capture is active in both FEED and DRAIN.
- Arithmetic: none in this block. C stores mm_out verbatim as a signed OW-bit value.
- go while busy: ignored.
- ld_en while busy: ignored; matrices are stable during a run.
- ld_en while IDLE: writes A or B[ld_addr] on that edge. ld_en together with go in the same cycle: the write commits and go is accepted; feeding uses the newly written value because first use is at t=1.
- c_rd_data during a run: reads return the current register contents, partially updated results included.
- NRST low mid-run: returns immediately to reset values, including the C register file; mm_start drops asynchronously.

Optional Feature:
MMS_TIMEOUT_EN
- Defined:
  - Add output err (1 bit, reset 0).
  - A DRAIN cycle counter starts at DRAIN entry.
  - If the count reaches TIMEOUT with result count<4, go to IDLE: busy=0, err=1 sticky, no done pulse.
  - err clears on the next accepted go.
- Undefined: no err port; DRAIN waits indefinitely.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE/FEED/DRAIN/DONE)
  - DW and OW defaults
  - the feed-schedule constants: DOT_PERIOD=5, SECOND_OPERAND_OFFSET=3, FEED_LEN=20, NUM_RESULTS=4
  - the signed element and result types.
- One natural sub-module: matmul_result_capture, covering strobe edge detect, result count and the C register file with its read mux.

Test Plan:
- Basic multiply: load A=[[1,2],[3,4]] and B=[[5,6],[7,8]], pulse go, with a cycle-accurate consumer model attached. Expect mm_start high for exactly 20 cycles, operand pairs at t=1,4,6,9,11,14,16,19, done at t=22, and C=[19,22,43,50].
- Negative extremes: A all -128, B all -128 gives C all 32768; A all -128, B all 127 gives C all -32512. Check signs through the full 17-bit width.
- Busy rules: go and ld_en (A[0]=99) pulsed at t=8 are both ignored; results stay those of the original A, and busy does not re-extend.
- Strobe edges: a 2-cycle-wide strobe and a 5th spurious strobe after done; exactly 4 captures occur and C is unchanged afterwards.
- Reset mid-run: NRST low at t=10 sends mm_start to 0 at once, clears busy and C, and no done appears. A following go runs cleanly with correct results.
- With MMS_TIMEOUT_EN: mm_strobe tied 0 gives err=1 and busy=0 at DRAIN entry + TIMEOUT with no done. The next go clears err.

Source files
------------

// File: rtl/matmul_operand_sequencer_pkg.sv
// Shared types and feed-schedule constants for the 2x2 matrix-multiply operand sequencer.
package matmul_operand_sequencer_pkg;

  localparam int DW_DEF = 8;
  localparam int OW_DEF = 2 * DW_DEF + 1;

  localparam int DOT_PERIOD            = 5;
  localparam int SECOND_OPERAND_OFFSET = 3;
  localparam int FEED_LEN              = 20;
  localparam int NUM_RESULTS           = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef logic signed [DW_DEF-1:0] elem_t;
  typedef logic signed [OW_DEF-1:0] result_t;

  // Flat register-file index of a 2x2 element, row-major.
  function automatic logic [1:0] elem_idx(input int row, input int col);
    return 2'(row * 2 + col);
  endfunction

endpackage

// File: rtl/matmul_result_capture.sv
// Result strobe edge detector, result counter and the C register file with its read mux.
module matmul_result_capture
  import matmul_operand_sequencer_pkg::*;
#(
  parameter int OW = OW_DEF
) (
  input  logic                 CLK,
  input  logic                 NRST,
  input  logic                 clr,
  input  logic                 active,
  input  logic                 mm_strobe,
  input  logic signed [OW-1:0] mm_out,
  input  logic [1:0]           c_rd_addr,
  output logic signed [OW-1:0] c_rd_data,
  output logic                 all_next
);

  logic                 strobe_p1;
  logic [2:0]           count;
  logic signed [OW-1:0] c_mem [NUM_RESULTS];
  logic                 fire;

  // mm_out is only trustworthy in the first strobe cycle, so capture on the rising edge.
  assign fire      = active && mm_strobe && !strobe_p1 && (count < 3'(NUM_RESULTS));
  assign all_next  = (count == 3'(NUM_RESULTS)) ||
                     (fire && (count == 3'(NUM_RESULTS - 1)));
  assign c_rd_data = c_mem[c_rd_addr];

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      strobe_p1 <= 1'b0;
      count     <= '0;
      for (int i = 0; i < NUM_RESULTS; i++) c_mem[i] <= '0;
    end else begin
      strobe_p1 <= mm_strobe;
      if (clr) begin
        count <= '0;
      end else if (fire) begin
        c_mem[count[1:0]] <= mm_out;
        count             <= count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/matmul_operand_sequencer.sv
// Initiator side of the 2x2 signed matrix-multiply stream: operand storage, feed FSM, result capture.
// Optional drain watchdog with sticky err output is enabled by defining MMS_TIMEOUT_EN.
module matmul_operand_sequencer
  import matmul_operand_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
`ifdef MMS_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 32
`endif
) (
  input  logic                 CLK,
  input  logic                 NRST,
  input  logic                 ld_en,
  input  logic                 ld_sel,
  input  logic [1:0]           ld_addr,
  input  logic signed [DW-1:0] ld_data,
  input  logic                 go,
  output logic                 busy,
  output logic                 done,
  output logic                 mm_start,
  output logic signed [DW-1:0] mm_a,
  output logic signed [DW-1:0] mm_b,
  input  logic signed [OW-1:0] mm_out,
  input  logic                 mm_strobe,
  input  logic [1:0]           c_rd_addr,
  output logic signed [OW-1:0] c_rd_data
`ifdef MMS_TIMEOUT_EN
  ,
  output logic                 err
`endif
);

  state_e               state, state_n;
  logic [4:0]           t, t_n;
  logic                 go_acc;
  logic                 all_next;
  logic signed [DW-1:0] a_mem [4];
  logic signed [DW-1:0] b_mem [4];
  logic signed [DW-1:0] a_n, b_n;

`ifdef MMS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] dcnt;
  logic          err_set;
`endif

  always_comb begin
    state_n = state;
    t_n     = t;
    go_acc  = 1'b0;
`ifdef MMS_TIMEOUT_EN
    err_set = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (go) begin
          state_n = S_FEED;
          t_n     = '0;
          go_acc  = 1'b1;
        end
      end
      S_FEED: begin
        if (t == 5'(FEED_LEN - 1)) state_n = S_DRAIN;
        else                       t_n     = t + 5'd1;
      end
      S_DRAIN: begin
        if (all_next) begin
          state_n = S_DONE;
        end
`ifdef MMS_TIMEOUT_EN
        else if (dcnt == TW'(TIMEOUT - 1)) begin
          state_n = S_IDLE;
          err_set = 1'b1;
        end
`endif
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operands for the cycle being entered: slot t=1+5j+3k carries A[j>>1][k] and B[k][j&1].
  always_comb begin
    a_n = '0;
    b_n = '0;
    if (state_n == S_FEED) begin
      for (int j = 0; j < NUM_RESULTS; j++) begin
        for (int k = 0; k < 2; k++) begin
          if (t_n == 5'(1 + DOT_PERIOD * j + SECOND_OPERAND_OFFSET * k)) begin
            a_n = a_mem[elem_idx(j / 2, k)];
            b_n = b_mem[elem_idx(k, j % 2)];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state    <= S_IDLE;
      t        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
    end else begin
      state    <= state_n;
      t        <= t_n;
      busy     <= (state_n != S_IDLE);
      done     <= (state_n == S_DONE);
      mm_start <= (state_n == S_FEED);
      mm_a     <= a_n;
      mm_b     <= b_n;
    end
  end

  // Writes land only while idle, so the operands are frozen for the whole run.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < 4; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (ld_en && (state == S_IDLE)) begin
      if (ld_sel) b_mem[ld_addr] <= ld_data;
      else        a_mem[ld_addr] <= ld_data;
    end
  end

`ifdef MMS_TIMEOUT_EN
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      dcnt <= '0;
      err  <= 1'b0;
    end else begin
      dcnt <= ((state == S_DRAIN) && (state_n == S_DRAIN)) ? dcnt + TW'(1) : '0;
      if (go_acc)       err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end
`endif

  matmul_result_capture #(
    .OW(OW)
  ) u_capture (
    .CLK       (CLK),
    .NRST      (NRST),
    .clr       (go_acc),
    .active    (state != S_IDLE),
    .mm_strobe (mm_strobe),
    .mm_out    (mm_out),
    .c_rd_addr (c_rd_addr),
    .c_rd_data (c_rd_data),
    .all_next  (all_next)
  );

endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Directed bench for matmul_operand_sequencer with a cycle-accurate multiply-accumulate consumer model.
module tb_matmul_operand_sequencer;
  import matmul_operand_sequencer_pkg::*;

  localparam int DW = 8;
  localparam int OW = 17;

  logic                 CLK  = 1'b0;
  logic                 NRST = 1'b0;
  logic                 ld_en = 1'b0;
  logic                 ld_sel = 1'b0;
  logic [1:0]           ld_addr = '0;
  logic signed [DW-1:0] ld_data = '0;
  logic                 go = 1'b0;
  logic                 busy, done, mm_start;
  logic signed [DW-1:0] mm_a, mm_b;
  logic signed [OW-1:0] mm_out = '0;
  logic                 mm_strobe = 1'b0;
  logic [1:0]           c_rd_addr = '0;
  logic signed [OW-1:0] c_rd_data;
`ifdef MMS_TIMEOUT_EN
  logic                 err;
`endif

  int checks = 0;
  int errors = 0;

  // consumer model state
  int      ccnt = 0;
  bit      crun = 1'b0;
  int      acc = 0;
  int      cres [4];
  int      strobe_w = 1;
  int      sage = 0;
  int      cyc = 0;
  int      spur_cyc = -1;
  result_t spur_val = '0;
  bit      cons_en = 1'b1;
  logic    prev_start = 1'b0;

  // per-cycle observations of one run, index = t
  logic                 obs_start [64];
  logic                 obs_busy  [64];
  logic                 obs_done  [64];
  logic signed [DW-1:0] obs_a     [64];
  logic signed [DW-1:0] obs_b     [64];
`ifdef MMS_TIMEOUT_EN
  logic                 obs_err   [64];
`endif
  result_t cval [4];

  matmul_operand_sequencer dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .go        (go),
    .busy      (busy),
    .done      (done),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_out    (mm_out),
    .mm_strobe (mm_strobe),
    .c_rd_addr (c_rd_addr),
    .c_rd_data (c_rd_data)
`ifdef MMS_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  always #5 CLK = ~CLK;

  // Consumer: samples at t=1+5j and 4+5j, strobes result j in cycle 6+5j.
  always @(negedge CLK) begin
    cyc++;
    if (!NRST) begin
      crun = 1'b0; ccnt = 0; prev_start = 1'b0; mm_strobe = 1'b0; sage = 0;
    end else begin
      if (mm_start && !prev_start) begin
        crun = 1'b1; ccnt = 0;
      end else if (crun) begin
        ccnt++;
      end
      prev_start = mm_start;
      if (mm_strobe) begin
        if (sage < strobe_w) begin
          sage++; mm_out = 17'h1ABCD;
        end else begin
          mm_strobe = 1'b0; mm_out = '0;
        end
      end
      if (crun) begin
        if (ccnt < 20 && ccnt % 5 == 1) acc = int'(mm_a) * int'(mm_b);
        if (ccnt < 20 && ccnt % 5 == 4) begin
          acc += int'(mm_a) * int'(mm_b);
          cres[2'(ccnt / 5)] = acc;
        end
        if (cons_en && ccnt >= 6 && ccnt <= 21 && (ccnt - 6) % 5 == 0) begin
          mm_strobe = 1'b1; sage = 1; mm_out = OW'(cres[2'((ccnt - 6) / 5)]);
        end
        if (ccnt >= 30) crun = 1'b0;
      end
      if (cyc == spur_cyc) begin
        mm_strobe = 1'b1; sage = 1; mm_out = spur_val;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_mats(input int a0, a1, a2, a3, b0, b1, b2, b3);
    int v [8];
    v = '{a0, a1, a2, a3, b0, b1, b2, b3};
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      ld_en = 1'b1; ld_sel = (i >= 4); ld_addr = 2'(i % 4); ld_data = 8'(v[3'(i)]);
    end
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  // Pulses go, then records n cycles starting at t=0; optionally injects go+ld_en at inj_t.
  task automatic run_mult(input int n, input int inj_t);
    @(negedge CLK); go = 1'b1;
    @(negedge CLK); go = 1'b0;
    for (int t = 0; t < n; t++) begin
      obs_start[6'(t)] = mm_start; obs_busy[6'(t)] = busy; obs_done[6'(t)] = done;
      obs_a[6'(t)] = mm_a; obs_b[6'(t)] = mm_b;
`ifdef MMS_TIMEOUT_EN
      obs_err[6'(t)] = err;
`endif
      if (t == inj_t) begin
        go = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 2'd0; ld_data = 8'sd99;
      end else if (t == inj_t + 1) begin
        go = 1'b0; ld_en = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  task automatic read_c();
    for (int i = 0; i < 4; i++) begin
      c_rd_addr = 2'(i);
      #1;
      cval[2'(i)] = c_rd_data;
    end
  endtask

  task automatic test_reset();
    NRST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL reset_mm_start: got %b want 0", mm_start); end
    checks++; if ({mm_a, mm_b} !== 16'h0) begin errors++; $display("FAIL reset_operands: got %0d/%0d want 0/0", mm_a, mm_b); end
    NRST = 1'b1;
    @(negedge CLK);
    read_c();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cval[2'(i)] !== '0) begin errors++; $display("FAIL reset_c%0d: got %0d want 0", i, cval[2'(i)]); end
    end
  endtask

  task automatic test_basic();
    int ea [20];
    int eb [20];
    int ec [4];
    logic signed [DW-1:0] xa, xb;
    ea = '{0, 1, 0, 0, 2, 0, 1, 0, 0, 2, 0, 3, 0, 0, 4, 0, 3, 0, 0, 4};
    eb = '{0, 5, 0, 0, 7, 0, 6, 0, 0, 8, 0, 5, 0, 0, 7, 0, 6, 0, 0, 8};
    ec = '{19, 22, 43, 50};
    load_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_mult(24, -1);
    for (int t = 0; t < 24; t++) begin
      xa = (t < 20) ? 8'(ea[5'(t)]) : 8'sd0;
      xb = (t < 20) ? 8'(eb[5'(t)]) : 8'sd0;
      checks++;
      if (obs_start[6'(t)] !== (t < 20)) begin errors++; $display("FAIL basic_mm_start t=%0d: got %b want %b", t, obs_start[6'(t)], t < 20); end
      checks++;
      if (obs_done[6'(t)] !== (t == 22)) begin errors++; $display("FAIL basic_done t=%0d: got %b want %b", t, obs_done[6'(t)], t == 22); end
      checks++;
      if (obs_busy[6'(t)] !== (t <= 22)) begin errors++; $display("FAIL basic_busy t=%0d: got %b want %b", t, obs_busy[6'(t)], t <= 22); end
      checks++;
      if ({obs_a[6'(t)], obs_b[6'(t)]} !== {xa, xb}) begin
        errors++; $display("FAIL basic_operands t=%0d: got %0d/%0d want %0d/%0d", t, obs_a[6'(t)], obs_b[6'(t)], xa, xb);
      end
    end
    read_c();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cval[2'(i)] !== OW'(ec[2'(i)])) begin errors++; $display("FAIL basic_c%0d: got %0d want %0d", i, cval[2'(i)], ec[2'(i)]); end
    end
  endtask

  task automatic test_extremes();
    result_t exp_pos, exp_neg;
    exp_pos = 17'sd32768;
    exp_neg = -17'sd32512;
    load_mats(-128, -128, -128, -128, -128, -128, -128, -128);
    run_mult(24, -1);
    checks++; if (obs_done[22] !== 1'b1) begin errors++; $display("FAIL ext_done: got %b want 1", obs_done[22]); end
    read_c();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cval[2'(i)] !== exp_pos) begin errors++; $display("FAIL ext_pos_c%0d: got %0d want %0d", i, cval[2'(i)], exp_pos); end
    end
    load_mats(-128, -128, -128, -128, 127, 127, 127, 127);
    run_mult(24, -1);
    read_c();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cval[2'(i)] !== exp_neg) begin errors++; $display("FAIL ext_neg_c%0d: got %0d want %0d", i, cval[2'(i)], exp_neg); end
    end
  endtask

  task automatic test_busy_rules();
    int ec [4];
    ec = '{19, 22, 43, 50};
    load_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_mult(26, 8);
    for (int t = 20; t < 26; t++) begin
      checks++;
      if (obs_done[6'(t)] !== (t == 22)) begin errors++; $display("FAIL busy_done t=%0d: got %b want %b", t, obs_done[6'(t)], t == 22); end
      checks++;
      if (obs_busy[6'(t)] !== (t <= 22)) begin errors++; $display("FAIL busy_extend t=%0d: got %b want %b", t, obs_busy[6'(t)], t <= 22); end
      checks++;
      if (obs_start[6'(t)] !== 1'b0) begin errors++; $display("FAIL busy_restart t=%0d: got %b want 0", t, obs_start[6'(t)]); end
    end
    read_c();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cval[2'(i)] !== OW'(ec[2'(i)])) begin errors++; $display("FAIL busy_c%0d: got %0d want %0d", i, cval[2'(i)], ec[2'(i)]); end
    end
    run_mult(24, -1);
    read_c();
    checks++; if (cval[0] !== 17'sd19) begin errors++; $display("FAIL busy_ld_ignored_c0: got %0d want 19", cval[0]); end
    checks++; if (cval[1] !== 17'sd22) begin errors++; $display("FAIL busy_ld_ignored_c1: got %0d want 22", cval[1]); end
  endtask

  task automatic test_strobe_edges();
    int ec [4];
    int ndone;
    ec = '{19, 22, 43, 50};
    strobe_w = 2;
    load_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_mult(24, -1);
    ndone = 0;
    for (int t = 0; t < 24; t++) if (obs_done[6'(t)] === 1'b1) ndone++;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL strobe_done_count: got %0d want 1", ndone); end
    checks++; if (obs_done[22] !== 1'b1) begin errors++; $display("FAIL strobe_done_t22: got %b want 1", obs_done[22]); end
    read_c();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cval[2'(i)] !== OW'(ec[2'(i)])) begin errors++; $display("FAIL strobe_wide_c%0d: got %0d want %0d", i, cval[2'(i)], ec[2'(i)]); end
    end
    strobe_w = 1;
    spur_val = 17'sd777;
    spur_cyc = cyc + 3;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL strobe_spurious_ctrl i=%0d: got done=%b busy=%b want 0/0", i, done, busy); end
    end
    read_c();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cval[2'(i)] !== OW'(ec[2'(i)])) begin errors++; $display("FAIL strobe_spurious_c%0d: got %0d want %0d", i, cval[2'(i)], ec[2'(i)]); end
    end
    spur_cyc = -1;
  endtask

  task automatic test_reset_midrun();
    int ec [4];
    ec = '{19, 22, 43, 50};
    load_mats(1, 2, 3, 4, 5, 6, 7, 8);
    @(negedge CLK); go = 1'b1;
    @(negedge CLK); go = 1'b0;
    repeat (10) @(negedge CLK);
    checks++; if (mm_start !== 1'b1) begin errors++; $display("FAIL rst_pre_mm_start: got %b want 1", mm_start); end
    NRST = 1'b0;
    #1;
    checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL rst_async_mm_start: got %b want 0", mm_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    checks++; if ({mm_a, mm_b} !== 16'h0) begin errors++; $display("FAIL rst_async_operands: got %0d/%0d want 0/0", mm_a, mm_b); end
    read_c();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cval[2'(i)] !== '0) begin errors++; $display("FAIL rst_c%0d: got %0d want 0", i, cval[2'(i)]); end
    end
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL rst_after i=%0d: got done=%b busy=%b want 0/0", i, done, busy); end
    end
    load_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_mult(24, -1);
    checks++; if (obs_done[22] !== 1'b1) begin errors++; $display("FAIL rst_rerun_done: got %b want 1", obs_done[22]); end
    read_c();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cval[2'(i)] !== OW'(ec[2'(i)])) begin errors++; $display("FAIL rst_rerun_c%0d: got %0d want %0d", i, cval[2'(i)], ec[2'(i)]); end
    end
  endtask

`ifdef MMS_TIMEOUT_EN
  task automatic test_timeout();
    int ndone;
    cons_en = 1'b0;
    load_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_mult(60, -1);
    ndone = 0;
    for (int t = 0; t < 60; t++) if (obs_done[6'(t)] === 1'b1) ndone++;
    checks++; if (ndone !== 0) begin errors++; $display("FAIL to_done_count: got %0d want 0", ndone); end
    checks++; if ({obs_busy[51], obs_err[51]} !== 2'b10) begin errors++; $display("FAIL to_t51: got busy=%b err=%b want 1/0", obs_busy[51], obs_err[51]); end
    checks++; if ({obs_busy[52], obs_err[52]} !== 2'b01) begin errors++; $display("FAIL to_t52: got busy=%b err=%b want 0/1", obs_busy[52], obs_err[52]); end
    checks++; if (obs_err[59] !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", obs_err[59]); end
    cons_en = 1'b1;
    run_mult(24, -1);
    checks++; if (obs_err[0] !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", obs_err[0]); end
    checks++; if (obs_done[22] !== 1'b1) begin errors++; $display("FAIL to_rerun_done: got %b want 1", obs_done[22]); end
    read_c();
    checks++; if (cval[3] !== 17'sd50) begin errors++; $display("FAIL to_rerun_c3: got %0d want 50", cval[3]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_busy_rules();
    test_strobe_edges();
    test_reset_midrun();
`ifdef MMS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
